mem_stage_controller: RTL and testbench
=======================================

MEM_STAGE_CONTROLLER -- requirements
Module: mem_stage_controller

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 CLK  in  1  single clock; all state changes on the rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 ex_mem_valid  in  1  EX/MEM register holds a live instruction.
REQ-005 alu_result  in  XLEN  memory address or ALU result.
REQ-006 alu_zero  in  1  ALU zero flag.
REQ-007 read_data_2  in  XLEN  store data.
REQ-008 func_3  in  3  load/store size and sign.
REQ-009 rd  in  5  destination register (instruction bits 11:7).
REQ-010 jump_pc, force_jump, branch  in  XLEN/1/1  branch target and branch controls.
REQ-011 mem_read, mem_write, reg_write, mem_to_reg, jump_rd  in  1 each  control bits from EX/MEM.
REQ-012 dmem_req, dmem_we  out  1  data-memory request and write strobe.
REQ-013 dmem_addr, dmem_wdata  out  XLEN  word-aligned address and lane-replicated write data.
REQ-014 dmem_be  out  4  byte enables.
REQ-015 dmem_rdata, dmem_ack  in  XLEN/1  read data and completion.
REQ-016 stall  out  1  freezes IF/ID/EX and the EX/MEM register.
REQ-017 pc_src, pc_target  out  1/XLEN  redirect request and target.
REQ-018 mem_wb_valid, mem_wb_read_data, mem_wb_alu_result, mem_wb_rd, mem_wb_reg_write, mem_wb_mem_to_reg, mem_wb_jump_rd  out  registered MEM/WB payload.
REQ-019 misalign_trap  out  1  misaligned-access pulse.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ and RESP.
REQ-021 IDLE, valid non-memory instruction: the payload SHALL be registered onto mem_wb_* with 1-cycle latency, without stall.
REQ-022 IDLE, valid memory instruction: the block SHALL go to REQ, latch addr/we/wdata/be/rd/controls, and hold stall high that cycle.
REQ-023 REQ: dmem_req SHALL be high, with dmem_addr/we/wdata/be stable until dmem_ack is sampled high, and stall SHALL remain high.
REQ-024 REQ with dmem_ack: the block SHALL capture and align dmem_rdata, then go to RESP.
REQ-025 RESP: mem_wb_valid SHALL be high for exactly one cycle, stall SHALL be low, and the next state SHALL be IDLE.
REQ-026 Minimum memory-op latency SHALL be 2 cycles from acceptance to mem_wb_valid (ack in the first REQ cycle).
REQ-027 func_3 decoding SHALL be: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; any other value SHALL decode as word.
REQ-028 dmem_be SHALL be 0001/0011/1111 shifted left by alu_result[1:0]; dmem_addr SHALL be {alu_result[XLEN-1:2],2'b00}.
REQ-029 Loads SHALL select lanes by address offset and sign- or zero-extend to XLEN.
REQ-030 pc_src SHALL be ex_mem_valid & (force_jump | (branch & alu_zero)) in IDLE, and 0 otherwise; pc_target SHALL equal jump_pc (combinational).
REQ-031 mem_wb_valid SHALL be 0 in every cycle not covered by REQ-021/REQ-025; the other mem_wb_* outputs SHALL hold.

Reset
REQ-032 RST SHALL force state IDLE and drive to 0: stall, dmem_req, dmem_we, dmem_be, pc_src, misalign_trap and all mem_wb_* outputs.
REQ-033 RST during REQ SHALL drop dmem_req at the next edge; a dmem_ack arriving afterwards SHALL be ignored.

Configuration
REQ-034 With MEM_STAGE_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no dmem_req, pulse misalign_trap for one cycle and emit mem_wb_valid with mem_wb_reg_write=0.
REQ-035 Without MEM_STAGE_MISALIGN_TRAP_EN, misalign_trap SHALL be tied 0, words SHALL align down, and halves SHALL ignore addr[0].

Structure
REQ-036 Package mem_stage_pkg SHALL hold XLEN, the func_3 enum, the FSM state enum and the MEM/WB payload struct.
REQ-037 Sub-module load_store_aligner SHALL be purely combinational and produce be, wdata replication and load extraction.

Verification
REQ-038 SW with addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> dmem_be=1111, stall high for 4 cycles, mem_wb_valid at cycle 5.
REQ-039 LB with addr 0x103 and rdata 0x80xxxxxx -> be=1000, mem_wb_read_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-040 LH with addr 0x102 and rdata 0x8001xxxx -> 0xFFFF8001; same-cycle ack -> mem_wb_valid 2 cycles after acceptance.
REQ-041 Branch with alu_zero=1, jump_pc=0x40 -> pc_src=1 and pc_target=0x40 in the same cycle; alu_zero=0 -> pc_src=0.
REQ-042 RST during REQ, then ack -> dmem_req=0 next cycle and no mem_wb_valid.
REQ-043 With macro defined, LW at 0x101 -> misalign_trap=1, dmem_req=0 and mem_wb_reg_write=0; without the macro -> dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: datapath width, load/store size codes,
// controller FSM states and the MEM/WB payload record.
package mem_stage_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } func3_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] read_data;
      logic [XLEN-1:0] alu_result;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_to_reg;
      logic            jump_rd;
   } mem_wb_t;

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// and extension. Misalignment detection exists only with MEM_STAGE_MISALIGN_TRAP_EN.
module load_store_aligner (
   input  logic [2:0]  func_3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misaligned
);
   import mem_stage_pkg::*;

   logic        is_byte;
   logic        is_half;
   logic        sext;
   logic [1:0]  eff_off;
   logic [31:0] shifted;

   // Unlisted size codes fall through to a full word access.
   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      sext    = 1'b0;
      case (func3_e'(func_3))
         F3_B:    begin is_byte = 1'b1; sext = 1'b1; end
         F3_H:    begin is_half = 1'b1; sext = 1'b1; end
         F3_BU:   is_byte = 1'b1;
         F3_HU:   is_half = 1'b1;
         default: ;
      endcase
   end

   // Halves drop addr[0] and words drop addr[1:0], so accesses never straddle a word.
   assign eff_off   = is_byte ? offset : (is_half ? {offset[1], 1'b0} : 2'b00);
   assign be        = is_byte ? (4'b0001 << eff_off) : (is_half ? (4'b0011 << eff_off) : 4'b1111);
   assign wdata     = is_byte ? {4{store_data[7:0]}} : (is_half ? {2{store_data[15:0]}} : store_data);
   assign shifted   = rdata >> {eff_off, 3'b000};
   assign load_data = is_byte ? {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]}
                    : (is_half ? {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]} : shifted);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign misaligned = (is_half & offset[0]) | (~is_byte & ~is_half & (|offset));
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_stage_controller.sv
// MEM stage controller: IDLE/REQ/RESP handshake with data memory, pipeline stall,
// branch redirect and registered MEM/WB payload. Optional: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_controller #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ex_mem_valid,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] read_data_2,
   input  logic [2:0]      func_3,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] jump_pc,
   input  logic            force_jump,
   input  logic            branch,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            reg_write,
   input  logic            mem_to_reg,
   input  logic            jump_rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            stall,
   output logic            pc_src,
   output logic [XLEN-1:0] pc_target,
   output logic            mem_wb_valid,
   output logic [XLEN-1:0] mem_wb_read_data,
   output logic [XLEN-1:0] mem_wb_alu_result,
   output logic [4:0]      mem_wb_rd,
   output logic            mem_wb_reg_write,
   output logic            mem_wb_mem_to_reg,
   output logic            mem_wb_jump_rd,
   output logic            misalign_trap
);
   import mem_stage_pkg::*;

   state_e          state_reg;
   logic            dmem_req_reg;
   logic            dmem_we_reg;
   logic [3:0]      dmem_be_reg;
   logic [XLEN-1:0] dmem_addr_reg;
   logic [XLEN-1:0] dmem_wdata_reg;
   logic [2:0]      func_3_reg;
   logic [1:0]      offset_reg;
   logic            misalign_reg;
   mem_wb_t         pend_reg;
   mem_wb_t         mem_wb_reg;

   logic            in_idle;
   logic            accept;
   logic            is_mem;
   logic [2:0]      al_func_3;
   logic [1:0]      al_offset;
   logic [3:0]      al_be;
   logic [31:0]     al_wdata;
   logic [31:0]     al_load;
   logic            al_misaligned;

   assign in_idle = (state_reg == ST_IDLE);
   assign accept  = in_idle & ex_mem_valid;
   assign is_mem  = mem_read | mem_write;

   // One aligner serves both phases: live inputs when accepting, latched ones while waiting.
   assign al_func_3 = in_idle ? func_3 : func_3_reg;
   assign al_offset = in_idle ? alu_result[1:0] : offset_reg;

   load_store_aligner u_aligner (
      .func_3     (al_func_3),
      .offset     (al_offset),
      .store_data (read_data_2),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load),
      .misaligned (al_misaligned)
   );

   // The EX/MEM register is held from acceptance until RESP, hence stall in both cycles.
   assign stall     = ~RST & ((accept & is_mem & ~al_misaligned) | (state_reg == ST_REQ));
   assign pc_src    = ~RST & accept & (force_jump | (branch & alu_zero));
   assign pc_target = jump_pc;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= ST_IDLE;
         dmem_req_reg   <= 1'b0;
         dmem_we_reg    <= 1'b0;
         dmem_be_reg    <= 4'b0000;
         dmem_addr_reg  <= '0;
         dmem_wdata_reg <= '0;
         func_3_reg     <= 3'b010;
         offset_reg     <= 2'b00;
         misalign_reg   <= 1'b0;
         pend_reg       <= '0;
         mem_wb_reg     <= '0;
      end else begin
         mem_wb_reg.valid <= 1'b0;
         misalign_reg     <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (ex_mem_valid) begin
                  if (is_mem && !al_misaligned) begin
                     state_reg           <= ST_REQ;
                     dmem_req_reg        <= 1'b1;
                     dmem_we_reg         <= mem_write;
                     dmem_be_reg         <= al_be;
                     dmem_addr_reg       <= {alu_result[XLEN-1:2], 2'b00};
                     dmem_wdata_reg      <= al_wdata;
                     func_3_reg          <= func_3;
                     offset_reg          <= alu_result[1:0];
                     pend_reg.valid      <= 1'b1;
                     pend_reg.read_data  <= '0;
                     pend_reg.alu_result <= alu_result;
                     pend_reg.rd         <= rd;
                     pend_reg.reg_write  <= reg_write;
                     pend_reg.mem_to_reg <= mem_to_reg;
                     pend_reg.jump_rd    <= jump_rd;
                  end else begin
                     // Non-memory op, or a trapped misaligned access that retires without writeback.
                     mem_wb_reg.valid      <= 1'b1;
                     mem_wb_reg.alu_result <= alu_result;
                     mem_wb_reg.rd         <= rd;
                     mem_wb_reg.reg_write  <= reg_write & ~(is_mem & al_misaligned);
                     mem_wb_reg.mem_to_reg <= mem_to_reg;
                     mem_wb_reg.jump_rd    <= jump_rd;
                     misalign_reg          <= is_mem & al_misaligned;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_ack) begin
                  state_reg            <= ST_RESP;
                  dmem_req_reg         <= 1'b0;
                  dmem_we_reg          <= 1'b0;
                  dmem_be_reg          <= 4'b0000;
                  mem_wb_reg           <= pend_reg;
                  mem_wb_reg.valid     <= 1'b1;
                  mem_wb_reg.read_data <= al_load;
               end
            end
            ST_RESP: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign dmem_req          = dmem_req_reg;
   assign dmem_we           = dmem_we_reg;
   assign dmem_be           = dmem_be_reg;
   assign dmem_addr         = dmem_addr_reg;
   assign dmem_wdata        = dmem_wdata_reg;
   assign misalign_trap     = misalign_reg;
   assign mem_wb_valid      = mem_wb_reg.valid;
   assign mem_wb_read_data  = mem_wb_reg.read_data;
   assign mem_wb_alu_result = mem_wb_reg.alu_result;
   assign mem_wb_rd         = mem_wb_reg.rd;
   assign mem_wb_reg_write  = mem_wb_reg.reg_write;
   assign mem_wb_mem_to_reg = mem_wb_reg.mem_to_reg;
   assign mem_wb_jump_rd    = mem_wb_reg.jump_rd;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed bench for mem_stage_controller: vector table for single-cycle ops plus
// hand-written memory handshake, reset-in-REQ and misalignment sequences.
module tb_mem_stage_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_mem_valid;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] read_data_2;
   logic [2:0]  func_3;
   logic [4:0]  rd;
   logic [31:0] jump_pc;
   logic        force_jump;
   logic        branch;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        mem_to_reg;
   logic        jump_rd;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        stall;
   logic        pc_src;
   logic [31:0] pc_target;
   logic        mem_wb_valid;
   logic [31:0] mem_wb_read_data;
   logic [31:0] mem_wb_alu_result;
   logic [4:0]  mem_wb_rd;
   logic        mem_wb_reg_write;
   logic        mem_wb_mem_to_reg;
   logic        mem_wb_jump_rd;
   logic        misalign_trap;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_stage_controller #(.XLEN(32)) dut (
      .CLK               (clk),
      .RST               (rst),
      .ex_mem_valid      (ex_mem_valid),
      .alu_result        (alu_result),
      .alu_zero          (alu_zero),
      .read_data_2       (read_data_2),
      .func_3            (func_3),
      .rd                (rd),
      .jump_pc           (jump_pc),
      .force_jump        (force_jump),
      .branch            (branch),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .reg_write         (reg_write),
      .mem_to_reg        (mem_to_reg),
      .jump_rd           (jump_rd),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_be           (dmem_be),
      .dmem_rdata        (dmem_rdata),
      .dmem_ack          (dmem_ack),
      .stall             (stall),
      .pc_src            (pc_src),
      .pc_target         (pc_target),
      .mem_wb_valid      (mem_wb_valid),
      .mem_wb_read_data  (mem_wb_read_data),
      .mem_wb_alu_result (mem_wb_alu_result),
      .mem_wb_rd         (mem_wb_rd),
      .mem_wb_reg_write  (mem_wb_reg_write),
      .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
      .mem_wb_jump_rd    (mem_wb_jump_rd),
      .misalign_trap     (misalign_trap)
   );

   typedef struct {
      logic        valid;
      logic [31:0] alu;
      logic        zero;
      logic        br;
      logic        fj;
      logic [31:0] jpc;
      logic        rw;
      logic [4:0]  rdst;
      logic        jrd;
      logic        exp_pc_src;
      logic        exp_wb_valid;
      logic [31:0] exp_wb_alu;
      logic [4:0]  exp_wb_rd;
      logic        exp_wb_rw;
      logic        exp_wb_jrd;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      ex_mem_valid = 1'b0; alu_result = '0; alu_zero = 1'b0; read_data_2 = '0;
      func_3 = 3'b010; rd = '0; jump_pc = '0; force_jump = 1'b0; branch = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
      jump_rd = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
   endtask

   // Starts and ends at a falling edge; cycle 1 is the acceptance cycle.
   task automatic mem_op(input logic [2:0] f3, input logic [31:0] addr, input logic is_store,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int ack_at,
                         output int stall_cnt, output int wb_cyc, output logic [3:0] be_s,
                         output logic [31:0] addr_s, output logic [31:0] wdata_s,
                         output logic we_s, output logic [31:0] wb_data);
      int cyc;
      int nreq;
      ex_mem_valid = 1'b1; func_3 = f3; alu_result = addr; read_data_2 = sdata;
      mem_read = ~is_store; mem_write = is_store; reg_write = ~is_store;
      mem_to_reg = ~is_store; rd = 5'd10; branch = 1'b0; force_jump = 1'b0;
      stall_cnt = 0; wb_cyc = 0; cyc = 1; nreq = 0;
      be_s = '0; addr_s = '0; wdata_s = '0; we_s = 1'b0; wb_data = '0;
      #1 if (stall) stall_cnt++;
      while (wb_cyc == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         dmem_ack = 1'b0;
         if (mem_wb_valid) begin
            wb_cyc  = cyc;
            wb_data = mem_wb_read_data;
         end else if (dmem_req) begin
            nreq++;
            be_s = dmem_be; addr_s = dmem_addr; wdata_s = dmem_wdata; we_s = dmem_we;
            if (nreq == ack_at) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
         end
         #1 if (stall) stall_cnt++;
      end
      ex_mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
      @(negedge clk);
      dmem_ack = 1'b0;
   endtask

   int          sc, wc;
   logic [3:0]  be_s;
   logic [31:0] addr_s, wdata_s, wb_data;
   logic        we_s;

   initial begin
      vecs[0] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 5'd5, 1'b0,
                  1'b0, 1'b1, 32'h12345678, 5'd5, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h40,  1'b0, 5'd0, 1'b0,
                  1'b1, 1'b1, 32'h0,        5'd0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h5,        1'b0, 1'b1, 1'b0, 32'h80,  1'b0, 5'd0, 1'b0,
                  1'b0, 1'b1, 32'h5,        5'd0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h1004,     1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 5'd1, 1'b1,
                  1'b1, 1'b1, 32'h1004,     5'd1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 32'hFFFF,     1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 5'd9, 1'b0,
                  1'b0, 1'b0, 32'h1004,     5'd1, 1'b1, 1'b1};

      // Reset with a live jump on the inputs: nothing may escape.
      clear_inputs();
      rst = 1'b1; ex_mem_valid = 1'b1; force_jump = 1'b1; mem_read = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_pc_src", {31'b0, pc_src}, 32'd0);
      check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
      check("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
      check("rst_wb_valid", {31'b0, mem_wb_valid}, 32'd0);
      check("rst_wb_rd", {27'b0, mem_wb_rd}, 32'd0);
      check("rst_trap", {31'b0, misalign_trap}, 32'd0);
      $display("reset: stall=%0b pc_src=%0b dmem_req=%0b", stall, pc_src, dmem_req);
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         ex_mem_valid = vecs[i].valid; alu_result = vecs[i].alu; alu_zero = vecs[i].zero;
         branch = vecs[i].br; force_jump = vecs[i].fj; jump_pc = vecs[i].jpc;
         reg_write = vecs[i].rw; rd = vecs[i].rdst; jump_rd = vecs[i].jrd;
         #1;
         check($sformatf("v%0d_pc_src", i), {31'b0, pc_src}, {31'b0, vecs[i].exp_pc_src});
         check($sformatf("v%0d_pc_target", i), pc_target, vecs[i].jpc);
         check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'd0);
         @(negedge clk);
         check($sformatf("v%0d_wb_valid", i), {31'b0, mem_wb_valid}, {31'b0, vecs[i].exp_wb_valid});
         check($sformatf("v%0d_wb_alu", i), mem_wb_alu_result, vecs[i].exp_wb_alu);
         check($sformatf("v%0d_wb_rd", i), {27'b0, mem_wb_rd}, {27'b0, vecs[i].exp_wb_rd});
         check($sformatf("v%0d_wb_rw", i), {31'b0, mem_wb_reg_write}, {31'b0, vecs[i].exp_wb_rw});
         check($sformatf("v%0d_wb_jrd", i), {31'b0, mem_wb_jump_rd}, {31'b0, vecs[i].exp_wb_jrd});
         $display("vec %0d: pc_src=%0b wb_valid=%0b wb_alu=%h", i, pc_src, mem_wb_valid, mem_wb_alu_result);
      end
      clear_inputs();
      @(negedge clk);

      // SW, ack in the third REQ cycle.
      mem_op(3'b010, 32'h100, 1'b1, 32'hDEADBEEF, 32'h0, 3, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("sw_be", {28'b0, be_s}, 32'h0000000F);
      check("sw_addr", addr_s, 32'h100);
      check("sw_wdata", wdata_s, 32'hDEADBEEF);
      check("sw_we", {31'b0, we_s}, 32'd1);
      check("sw_stall_cycles", sc, 32'd4);
      check("sw_wb_cycle", wc, 32'd5);
      $display("sw: be=%b stall_cycles=%0d wb_cycle=%0d", be_s, sc, wc);

      mem_op(3'b000, 32'h103, 1'b0, 32'h0, 32'h80123456, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("lb_be", {28'b0, be_s}, 32'h00000008);
      check("lb_addr", addr_s, 32'h100);
      check("lb_we", {31'b0, we_s}, 32'd0);
      check("lb_data", wb_data, 32'hFFFFFF80);
      check("lb_wb_cycle", wc, 32'd3);
      $display("lb: be=%b data=%h wb_cycle=%0d", be_s, wb_data, wc);

      mem_op(3'b100, 32'h103, 1'b0, 32'h0, 32'h80123456, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("lbu_data", wb_data, 32'h00000080);
      $display("lbu: data=%h", wb_data);

      mem_op(3'b001, 32'h102, 1'b0, 32'h0, 32'h80011234, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("lh_be", {28'b0, be_s}, 32'h0000000C);
      check("lh_data", wb_data, 32'hFFFF8001);
      check("lh_wb_cycle", wc, 32'd3);
      check("lh_stall_cycles", sc, 32'd2);
      $display("lh: be=%b data=%h wb_cycle=%0d", be_s, wb_data, wc);

      mem_op(3'b101, 32'h100, 1'b0, 32'h0, 32'h1234F00D, 2, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("lhu_data", wb_data, 32'h0000F00D);
      check("lhu_wb_cycle", wc, 32'd4);
      $display("lhu: data=%h wb_cycle=%0d", wb_data, wc);

      mem_op(3'b000, 32'h101, 1'b1, 32'h000000AB, 32'h0, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("sb_be", {28'b0, be_s}, 32'h00000002);
      check("sb_wdata", wdata_s, 32'hABABABAB);
      $display("sb: be=%b wdata=%h", be_s, wdata_s);

      mem_op(3'b001, 32'h106, 1'b1, 32'h0000BEEF, 32'h0, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("sh_be", {28'b0, be_s}, 32'h0000000C);
      check("sh_addr", addr_s, 32'h104);
      check("sh_wdata", wdata_s, 32'hBEEFBEEF);
      $display("sh: be=%b addr=%h wdata=%h", be_s, addr_s, wdata_s);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      ex_mem_valid = 1'b1; func_3 = 3'b010; alu_result = 32'h101; mem_read = 1'b1;
      reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd7;
      @(negedge clk);
      check("mis_trap", {31'b0, misalign_trap}, 32'd1);
      check("mis_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("mis_wb_valid", {31'b0, mem_wb_valid}, 32'd1);
      check("mis_wb_rw", {31'b0, mem_wb_reg_write}, 32'd0);
      $display("lw misaligned: trap=%0b req=%0b wb_rw=%0b", misalign_trap, dmem_req, mem_wb_reg_write);
      clear_inputs();
      @(negedge clk);
      check("mis_trap_pulse", {31'b0, misalign_trap}, 32'd0);
`else
      mem_op(3'b010, 32'h101, 1'b0, 32'h0, 32'hCAFEF00D, 1, sc, wc, be_s, addr_s, wdata_s, we_s, wb_data);
      check("lw_mis_addr", addr_s, 32'h100);
      check("lw_mis_be", {28'b0, be_s}, 32'h0000000F);
      check("lw_mis_data", wb_data, 32'hCAFEF00D);
      check("lw_mis_trap", {31'b0, misalign_trap}, 32'd0);
      $display("lw misaligned: addr=%h data=%h", addr_s, wb_data);
`endif

      // Reset while a request is outstanding; a late ack must be ignored.
      ex_mem_valid = 1'b1; func_3 = 3'b010; alu_result = 32'h200; mem_read = 1'b1; reg_write = 1'b1;
      @(negedge clk);
      check("rreq_req_before", {31'b0, dmem_req}, 32'd1);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("rreq_req_after", {31'b0, dmem_req}, 32'd0);
      rst = 1'b0;
      dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rreq_wb_valid%0d", k), {31'b0, mem_wb_valid}, 32'd0);
         check($sformatf("rreq_req%0d", k), {31'b0, dmem_req}, 32'd0);
      end
      dmem_ack = 1'b0;
      $display("reset in REQ: req=%0b wb_valid=%0b", dmem_req, mem_wb_valid);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
